led_chaser: RTL
===============

// Module: led_chaser
// PURPOSE
//  Parametrised next-generation LED flow controller: drives an LED_W-wide bank with one of four
//  runtime-selectable patterns, stepped by an internal prescaler with runtime speed select and pause.
//  Sits between the board clock/reset and the LED pins.
//  Replaces the fixed single-pattern flow block with width, speed, mode and pause control.
// PARAMETERS
//  LED_W        4         number of LEDs (>=2)
//  STEP_CYCLES  25000000  clk cycles per pattern step at speed_sel=0 (>=8)
//  PWM_BITS     8         duty/PWM counter width (used only with LED_PWM_EN)
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         reset
//  mode       in   2         0 rotate-left, 1 rotate-right, 2 ping-pong, 3 bar fill/clear
//  speed_sel  in   2         step period = STEP_CYCLES >> speed_sel
//  pause      in   1         1 = freeze prescaler and pattern
//  duty       in   PWM_BITS  brightness (present only with LED_PWM_EN)
//  led_out    out  LED_W     LED drive, 1 = lit
//  step_pulse out  1         1-cycle strobe, high in the cycle led_out takes a new step
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
//  Reset values:
//   - pattern/led_out = 1 (bit0 only); step_pulse = 0; prescaler = 0
//   - direction = left; mode_q = 0
//  Prescaler:
//   - period P = STEP_CYCLES >> speed_sel; counts 0..P-1; tick when count == P-1, then count <= 0
//   - speed_sel is sampled every cycle; if count > new P-1, tick on the next cycle and wrap
//  Pause:
//   - counter and pattern hold; no ticks; step_pulse = 0
//   - deassert resumes from the held count
//  Step on tick; led_out and step_pulse are registered and update on the wrapping edge:
//   - mode0: pattern <= {p[W-2:0], p[W-1]}
//   - mode1: pattern <= {p[0], p[W-1:1]}
//   - mode2: single LED bounces; dir flips on the step that reaches bit W-1 or bit 0;
//     no repeat at the ends (W=4: 0001,0010,0100,1000,0100,0010,0001,0010..)
//   - mode3: all-ones -> 0, else pattern <= {p[W-2:0],1'b1} (0001,0011,0111,1111,0000,0001..)
//  Mode change:
//   - mode != mode_q detected in a cycle -> next edge: pattern = 1, dir = left, count = 0,
//     mode_q = mode, step_pulse = 0
//   - overrides a coincident tick; applies even while paused
//  Entering modes 0-2 with a multi-bit pattern cannot occur; the mode-change reload guarantees one-hot.
//  rst_n low mid-step: immediate return to reset values regardless of pause or mode.
// CONFIGURATION
//  LED_PWM_EN defined:
//   - adds duty port and a free-running PWM_BITS counter (reset 0)
//   - led_out = pattern & {W{pwm_cnt < duty}}, registered
//   - duty = 0 -> all dark; duty = 2^PWM_BITS-1 -> lit 255/256 of cycles (PWM_BITS = 8)
//   - step timing is unchanged
//  LED_PWM_EN undefined: no duty port, no PWM counter; led_out = pattern.
// TESTING (LED_W=4, STEP_CYCLES=16)
//  1. Reset release, mode=0, speed=0:
//     led_out 0001 -> 0010 -> 0100 -> 1000 -> 0001, one step per 16 clk;
//     step_pulse is one cycle per step.
//  2. mode=2, speed=2 (P=4):
//     0001,0010,0100,1000,0100,0010,0001,0010 at 4-clk spacing.
//  3. mode=3:
//     0001,0011,0111,1111,0000,0001.
//     Switch to mode=1 in the same cycle as a tick: led_out = 0001, no step_pulse;
//     next step at +16 clk gives 1000.
//  4. pause=1 for 40 clk mid-count (count=5):
//     led_out frozen, no step_pulse; after release the step occurs 11 clk later.
//  5. rst_n pulsed low asynchronously mid-pattern (led_out=0100):
//     led_out = 0001 and step_pulse = 0 immediately, before the next clk edge.
//  6. LED_PWM_EN, duty=64, mode=0:
//     lit LED high 64 of every 256 clk; duty=0 -> led_out = 0000 throughout.

Source files
------------

// File: rtl/led_chaser.sv
// led_chaser: LED flow controller for an LED_W-wide bank.
// It shows one of four patterns, which can be changed at run time. An internal
// prescaler sets the step rate. The prescaler has a speed select and a pause input.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   mode       0 rotate-left, 1 rotate-right, 2 ping-pong, 3 bar fill/clear
//   speed_sel  step period = STEP_CYCLES >> speed_sel
//   pause      1 = freeze prescaler and pattern
//   duty       PWM brightness (only when LED_PWM_EN is defined)
//   led_out    LED drive, 1 = lit (registered)
//   step_pulse one-cycle strobe, high in the cycle led_out takes a new step
//
// Optional feature macro: LED_PWM_EN (adds duty port and PWM dimming).
module led_chaser #(
   parameter int LED_W       = 4,
   parameter int STEP_CYCLES = 25000000,
   parameter int PWM_BITS    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          mode,
   input  logic [1:0]          speed_sel,
   input  logic                pause,
`ifdef LED_PWM_EN
   input  logic [PWM_BITS-1:0] duty,
`endif
   output logic [LED_W-1:0]    led_out,
   output logic                step_pulse
);

   localparam int CW = $clog2(STEP_CYCLES);

   typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

   logic [CW-1:0]    count, count_nxt, period_m1;
   logic [31:0]      period;
   logic [LED_W-1:0] pattern, pattern_nxt, stepped;
   dir_t             dir, dir_nxt;
   logic [1:0]       mode_q;
   logic             tick, pulse_nxt;

   assign period    = 32'(STEP_CYCLES) >> speed_sel;
   assign period_m1 = CW'(period - 32'd1);
   // ">=" so a count left above a freshly shortened period wraps straight away
   assign tick      = !pause && (count >= period_m1);

   // Pattern advance, evaluated only when a tick is taken
   always_comb begin
      stepped = pattern;
      dir_nxt = dir;
      case (mode_q)
         2'd0: stepped = {pattern[LED_W-2:0], pattern[LED_W-1]};
         2'd1: stepped = {pattern[0], pattern[LED_W-1:1]};
         2'd2: begin
            if (dir == DIR_LEFT) begin
               stepped = {pattern[LED_W-2:0], 1'b0};
               if (stepped[LED_W-1]) dir_nxt = DIR_RIGHT;
            end else begin
               stepped = {1'b0, pattern[LED_W-1:1]};
               if (stepped[0]) dir_nxt = DIR_LEFT;
            end
         end
         default: stepped = (&pattern) ? '0 : {pattern[LED_W-2:0], 1'b1};
      endcase
   end

   // Mode change wins over a coincident tick and over pause
   logic mode_chg;
   dir_t dir_sel;
   assign mode_chg = (mode != mode_q);

   always_comb begin
      pattern_nxt = pattern;
      count_nxt   = count;
      dir_sel     = dir;
      pulse_nxt   = 1'b0;
      if (mode_chg) begin
         pattern_nxt = LED_W'(1);
         count_nxt   = '0;
         dir_sel     = DIR_LEFT;
      end else if (!pause) begin
         if (tick) begin
            pattern_nxt = stepped;
            dir_sel     = dir_nxt;
            count_nxt   = '0;
            pulse_nxt   = 1'b1;
         end else begin
            count_nxt = count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern    <= LED_W'(1);
         count      <= '0;
         dir        <= DIR_LEFT;
         mode_q     <= 2'd0;
         step_pulse <= 1'b0;
      end else begin
         pattern    <= pattern_nxt;
         count      <= count_nxt;
         dir        <= dir_sel;
         mode_q     <= mode;
         step_pulse <= pulse_nxt;
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [LED_W-1:0]    led_q;

   // Gate the next pattern so that dimming does not delay the step edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         led_q   <= LED_W'(1);
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         led_q   <= pattern_nxt & {LED_W{pwm_cnt < duty}};
      end
   end
   assign led_out = led_q;
`else
   assign led_out = pattern;
`endif

endmodule
